// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: default hypervector width,
// bundler FSM states and the counter-width helper.
package hdc_pkg;

   localparam int unsigned DIMENSIONS_DEFAULT = 10000;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } bundler_state_e;

   // Bits needed to hold a count from 0 to n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/hv_bit_acc.sv
// Per-bit majority accumulator: one vote counter plus threshold/tie compare.
// Define HV_TIEBREAK_LAST_EN to resolve even-window ties to the closing sample bit.
module hv_bit_acc
   import hdc_pkg::*;
#(
   parameter int unsigned WINDOW = 256
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_inc,
   input  logic i_clear,
   input  logic i_bit,
   output logic o_vote_c
);

   localparam int unsigned CW = cnt_width(WINDOW);
   localparam logic [CW-1:0] HALF = CW'(WINDOW / 2);
   localparam bit EVEN_WINDOW = (WINDOW % 2) == 0;

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_final;

   // Count as it stands once the current (closing) sample is included.
   assign w_final = r_cnt + CW'(i_bit);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

`ifdef HV_TIEBREAK_LAST_EN
   assign o_vote_c = (w_final > HALF) || (EVEN_WINDOW && (w_final == HALF) && i_bit);
`else
   assign o_vote_c = (w_final > HALF) && (EVEN_WINDOW || !EVEN_WINDOW);
`endif

endmodule

// File: rtl/hv_window_bundler.sv
// Bundles WINDOW sample hypervectors into one majority hypervector per window.
// Optional macro HV_TIEBREAK_LAST_EN: even-window ties take the closing sample's bit.
module hv_window_bundler
   import hdc_pkg::*;
#(
   parameter int unsigned DIMENSIONS = DIMENSIONS_DEFAULT,
   parameter int unsigned WINDOW     = 256,
   localparam int unsigned CW        = cnt_width(WINDOW)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  flush,
   input  logic [DIMENSIONS-1:0] sample_hv,
   output logic [DIMENSIONS-1:0] out_hv,
   output logic                  out_valid,
   output logic [CW-1:0]         sample_cnt
);

   bundler_state_e        r_state;
   bundler_state_e        w_state_nxt;
   logic [CW-1:0]         r_sample_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  w_accept;
   logic                  w_close;
   logic [DIMENSIONS-1:0] w_votes;
   logic [DIMENSIONS-1:0] r_out_hv;
   logic                  r_out_valid;

   // Flush wins over en: a sample arriving with flush is dropped.
   assign w_accept = en && !flush;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state      <= ST_IDLE;
         r_sample_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_sample_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_sample_cnt;
      w_close     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_ACCUM;
               w_cnt_nxt   = CW'(1);
            end
         end
         ST_ACCUM: begin
            if (flush) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (en) begin
               if (r_sample_cnt == CW'(WINDOW - 1)) begin
                  w_close     = 1'b1;
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_sample_cnt + CW'(1);
               end
            end
         end
      endcase
   end

   for (genvar g = 0; g < int'(DIMENSIONS); g++) begin : g_bit
      hv_bit_acc #(
         .WINDOW (WINDOW)
      ) u_acc (
         .clk      (clk),
         .nrst     (nrst),
         .i_inc    (w_accept && sample_hv[g]),
         .i_clear  (flush || w_close),
         .i_bit    (sample_hv[g]),
         .o_vote_c (w_votes[g])
      );
   end

   // Result is captured on the closing edge and held until the next close.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_out_hv    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_close;
         if (w_close) begin
            r_out_hv <= w_votes;
         end
      end
   end

   assign out_hv     = r_out_hv;
   assign out_valid  = r_out_valid;
   assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_hv_window_bundler.sv
// Bench for hv_window_bundler: WINDOW=3 and WINDOW=4 instances, DIMENSIONS=5,
// checked every cycle against a sample-list majority model plus literal expectations.
module tb_hv_window_bundler;

`ifdef HV_TIEBREAK_LAST_EN
   localparam bit TIE_LAST = 1'b1;
`else
   localparam bit TIE_LAST = 1'b0;
`endif

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic       en3 = 1'b0, fl3 = 1'b0;
   logic [4:0] s3  = '0;
   logic       en4 = 1'b0, fl4 = 1'b0;
   logic [4:0] s4  = '0;
   logic [4:0] oh3, oh4;
   logic       ov3, ov4;
   logic [1:0] sc3;
   logic [2:0] sc4;

   hv_window_bundler #(.DIMENSIONS(5), .WINDOW(3)) u_w3 (
      .clk(clk), .nrst(nrst), .en(en3), .flush(fl3), .sample_hv(s3),
      .out_hv(oh3), .out_valid(ov3), .sample_cnt(sc3));

   hv_window_bundler #(.DIMENSIONS(5), .WINDOW(4)) u_w4 (
      .clk(clk), .nrst(nrst), .en(en4), .flush(fl4), .sample_hv(s4),
      .out_hv(oh4), .out_valid(ov4), .sample_cnt(sc4));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: keep the window's samples, take per-bit majority when the window fills.
   logic [4:0] win [2][4];
   int         n   [2];
   logic [4:0] exp_hv [2];
   logic       exp_ov [2];

   function automatic logic [4:0] majority(input int i, input int w, input logic [4:0] last);
      logic [4:0] r;
      for (int b = 0; b < 5; b++) begin
         int sum;
         sum = 0;
         for (int k = 0; k < w; k++) sum += int'(win[i][k][b]);
         if (sum > w / 2) r[b] = 1'b1;
         else if (w % 2 == 0 && sum == w / 2 && TIE_LAST) r[b] = last[b];
         else r[b] = 1'b0;
      end
      return r;
   endfunction

   task automatic model_upd(input int i, input logic e, input logic f,
                            input logic [4:0] s, input int w);
      exp_ov[i] = 1'b0;
      if (f) begin
         n[i] = 0;
      end else if (e) begin
         win[i][n[i]] = s;
         n[i]++;
         if (n[i] == w) begin
            exp_hv[i] = majority(i, w, s);
            exp_ov[i] = 1'b1;
            n[i]      = 0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         n[i] = 0; exp_hv[i] = '0; exp_ov[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (!nrst) begin
         for (int i = 0; i < 2; i++) begin
            n[i] = 0; exp_hv[i] = '0; exp_ov[i] = 1'b0;
         end
      end else begin
         model_upd(0, en3, fl3, s3, 3);
         model_upd(1, en4, fl4, s4, 4);
      end
      #1;
      chk("w3_out_hv",     32'(oh3), 32'(exp_hv[0]));
      chk("w3_out_valid",  32'(ov3), 32'(exp_ov[0]));
      chk("w3_sample_cnt", 32'(sc3), 32'(n[0]));
      chk("w4_out_hv",     32'(oh4), 32'(exp_hv[1]));
      chk("w4_out_valid",  32'(ov4), 32'(exp_ov[1]));
      chk("w4_sample_cnt", 32'(sc4), 32'(n[1]));
   end

   task automatic drv(input int inst, input logic e, input logic f, input logic [4:0] s);
      @(negedge clk);
      en3 = 1'b0; fl3 = 1'b0; s3 = '0;
      en4 = 1'b0; fl4 = 1'b0; s4 = '0;
      if (inst == 0) begin en3 = e; fl3 = f; s3 = s; end
      else begin en4 = e; fl4 = f; s4 = s; end
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) drv(0, 1'b0, 1'b0, 5'b0);
   endtask

   int         sc_seq [9];
   int         pulse_pos [$];

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_oh3", 32'(oh3), 32'h0);
      chk("reset_ov3", 32'(ov3), 32'h0);
      chk("reset_sc3", 32'(sc3), 32'h0);
      chk("reset_oh4", 32'(oh4), 32'h0);
      chk("reset_ov4", 32'(ov4), 32'h0);
      chk("reset_sc4", 32'(sc4), 32'h0);
      nrst = 1'b1;
      idle(1);

      // WINDOW=3 back-to-back majority
      drv(0, 1, 0, 5'b11111);
      drv(0, 1, 0, 5'b10001);
      drv(0, 1, 0, 5'b00111);
      idle(1);
      chk("w3_b2b_hv",    32'(oh3), 32'h17);
      chk("w3_b2b_valid", 32'(ov3), 32'h1);
      idle(1);
      chk("w3_b2b_pulse_end", 32'(ov3), 32'h0);
      chk("w3_b2b_hold",      32'(oh3), 32'h17);

      // WINDOW=4 even tie
      drv(1, 1, 0, 5'b00000);
      drv(1, 1, 0, 5'b11111);
      drv(1, 1, 0, 5'b00000);
      drv(1, 1, 0, 5'b11111);
      idle(1);
      chk("w4_tie_hv",    32'(oh4), TIE_LAST ? 32'h1f : 32'h0);
      chk("w4_tie_valid", 32'(ov4), 32'h1);

      // WINDOW=3 zero window, then gapped samples
      repeat (3) drv(0, 1, 0, 5'b00000);
      idle(1);
      chk("w3_zero_hv", 32'(oh3), 32'h0);
      drv(0, 1, 0, 5'b11111);
      idle(2);
      drv(0, 1, 0, 5'b10001);
      idle(1);
      drv(0, 1, 0, 5'b00111);
      idle(1);
      chk("w3_gap_hv",    32'(oh3), 32'h17);
      chk("w3_gap_valid", 32'(ov3), 32'h1);
      idle(3);
      chk("w3_gap_hold",  32'(oh3), 32'h17);
      chk("w3_gap_quiet", 32'(ov3), 32'h0);

      // WINDOW=4 continuous en for 8 cycles
      for (int k = 0; k < 8; k++) begin
         drv(1, 1, 0, 5'($urandom));
         sc_seq[k] = int'(sc4);
         if (ov4) pulse_pos.push_back(k);
      end
      idle(1);
      sc_seq[8] = int'(sc4);
      if (ov4) pulse_pos.push_back(8);
      for (int k = 0; k < 9; k++) chk("w4_cont_cnt_seq", 32'(sc_seq[k]), 32'(k % 4));
      chk("w4_cont_pulses", 32'(pulse_pos.size()), 32'd2);
      if (pulse_pos.size() == 2)
         chk("w4_cont_spacing", 32'(pulse_pos[1] - pulse_pos[0]), 32'd4);

      // WINDOW=4 flush together with en
      drv(1, 1, 0, 5'b00000);
      drv(1, 1, 0, 5'b00000);
      drv(1, 1, 1, 5'b11111);
      idle(1);
      chk("w4_flush_cnt",   32'(sc4), 32'h0);
      chk("w4_flush_valid", 32'(ov4), 32'h0);
      repeat (4) drv(1, 1, 0, 5'b11111);
      idle(1);
      chk("w4_post_flush_hv",    32'(oh4), 32'h1f);
      chk("w4_post_flush_valid", 32'(ov4), 32'h1);

      // WINDOW=4 reset mid-window
      repeat (3) drv(1, 1, 0, 5'b00000);
      idle(1);
      nrst = 1'b0;
      #1;
      chk("rst_async_oh4", 32'(oh4), 32'h0);
      chk("rst_async_ov4", 32'(ov4), 32'h0);
      chk("rst_async_sc4", 32'(sc4), 32'h0);
      chk("rst_async_oh3", 32'(oh3), 32'h0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (4) drv(1, 1, 0, 5'b10101);
      idle(1);
      chk("w4_post_rst_hv",    32'(oh4), 32'h15);
      chk("w4_post_rst_valid", 32'(ov4), 32'h1);

      // Randomized traffic on both instances
      repeat (3000) begin
         @(negedge clk);
         en3 = ($urandom_range(0, 9) < 7);
         fl3 = ($urandom_range(0, 19) == 0);
         s3  = 5'($urandom);
         en4 = ($urandom_range(0, 9) < 7);
         fl4 = ($urandom_range(0, 19) == 0);
         s4  = 5'($urandom);
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
